z_run_controller: RTL

- Sequencer for the processor Z core: accepts a program from a host over a valid/ready stream and writes it into instruction RAM through the core's addr/wr/wdata load port.
- Pads the program tail with NOP words, then asserts working for exactly the cycles needed to fetch and drain the program.
- Reports done, abort and cycle-count status.
- Sits between the host/testbench and the processor top-level; replaces hand-timed load/working sequences.

---
 rtl/z_run_controller.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/z_run_controller.sv
// Run sequencer for processor Z: streams a program into instruction RAM,
// pads it with NOPs, then drives working for the fetch + drain window.
// Ports:
//   clock, reset             clock and synchronous active-high reset
//   ld_valid/ld_data/ld_last host program stream in, ld_ready back
//   start, abort, run_limit  run control (run_limit 0 = unlimited)
//   mem_addr/mem_wr/mem_wdata instruction RAM load port
//   working                  processor enable
//   prog_len, cycle_count    program length and RUN cycle count
//   busy, done, aborted      status
module z_run_controller #(
  parameter int              AW        = 9,
  parameter int              DW        = 32,
  parameter int              PAD_WORDS = 4,
  parameter logic [DW-1:0]   NOP_WORD  = '0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic          start,
  input  logic          abort,
  input  logic [15:0]   run_limit,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  output logic          working,
  output logic [AW:0]   prog_len,
  output logic [15:0]   cycle_count,
  output logic          busy,
  output logic          done,
  output logic          aborted
);

  localparam int CW = $clog2(PAD_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PAD,
    S_LOADED,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] wptr;
  logic [CW-1:0] pcnt;
  logic [AW:0]   fcnt;

  logic hs;
  logic full;
  logic lim_hit;
  logic run_end;

  assign ld_ready = (state == S_IDLE) || (state == S_LOAD);
  assign busy     = (state == S_LOAD) || (state == S_PAD) ||
                    (state == S_RUN)  || (state == S_DRAIN);

  assign hs   = ld_valid && ld_ready;
  // Last free RAM slot: the program ends here even without ld_last.
  assign full = &wptr;

  // Saturated count wraps the +1 to 0, which never equals a nonzero limit.
  assign lim_hit = (run_limit != 16'd0) &&
                   ((cycle_count + 16'd1) == run_limit);
  assign run_end = ((fcnt + 1'b1) == prog_len) || lim_hit || abort;

  // pcnt counts pad writes in PAD and drain cycles in DRAIN.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      wptr        <= '0;
      pcnt        <= '0;
      fcnt        <= '0;
      mem_addr    <= '0;
      mem_wr      <= 1'b0;
      mem_wdata   <= '0;
      working     <= 1'b0;
      prog_len    <= '0;
      cycle_count <= '0;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      unique case (state)
        S_IDLE, S_LOAD: begin
          if (hs) begin
            mem_wr    <= 1'b1;
            mem_addr  <= wptr;
            mem_wdata <= ld_data;
            wptr      <= wptr + 1'b1;
            prog_len  <= prog_len + 1'b1;
            state     <= (ld_last || full) ? S_PAD : S_LOAD;
          end
        end
        S_PAD: begin
          mem_wr    <= 1'b1;
          mem_addr  <= wptr;
          mem_wdata <= NOP_WORD;
          wptr      <= wptr + 1'b1;
          pcnt      <= pcnt + 1'b1;
          if (pcnt == CW'(PAD_WORDS - 1)) begin
            state <= S_LOADED;
          end
        end
        S_LOADED: begin
          if (start) begin
            state   <= S_RUN;
            working <= 1'b1;
            fcnt    <= '0;
          end
        end
        S_RUN: begin
          fcnt <= fcnt + 1'b1;
          if (cycle_count != 16'hFFFF) begin
            cycle_count <= cycle_count + 16'd1;
          end
          if (run_end) begin
            state <= S_DRAIN;
            pcnt  <= '0;
            if (lim_hit || abort) begin
              aborted <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          pcnt <= pcnt + 1'b1;
          if (pcnt == CW'(PAD_WORDS - 1)) begin
            state   <= S_DONE;
            working <= 1'b0;
            done    <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
